fifo_rdout_sched: RTL and testbench
===================================

Name: fifo_rdout_sched

Overview:
Readout scheduler for the per-ADC sample FIFOs on the DCFEB. For each accepted trigger it reads a fixed burst from each channel FIFO in turn and merges the words into one ordered output stream toward the frame builder. It starts only once the FIFO reset sequencer reports the FIFOs are clean. It aborts cleanly when that ready indication drops, for example on an ADC link restart.

Parameters:
NFIFO, 6, number of channel FIFOs (one per ADC chip)
WORD_W, 12, FIFO and output word width
BURST, 16, words read from each FIFO per event
TMO, 8, maximum stall cycles on an empty FIFO before padding (TMO >= 2)

Ports:
CLK  in  1  clock
RST  in  1  reset, asynchronous, active-high
FIFO_RDY  in  1  FIFO reset sequence complete; level, high while readout is permitted
TRIG  in  1  readout request, one pulse per event, synchronous to CLK
EMPTY  in  NFIFO  per-FIFO empty flags
DIN  in  NFIFO*WORD_W  FIFO data; channel k occupies bits [k*WORD_W +: WORD_W]; valid the cycle after RD_EN[k]
RD_EN  out  NFIFO  per-FIFO read strobe; one-hot or zero
DOUT  out  WORD_W  merged output word
DOUT_VLD  out  1  DOUT valid
DOUT_LAST  out  1  marks the final word of an event (word NFIFO*BURST-1)
PEND  out  4  pending-trigger count
TRIG_OVF  out  1  sticky: trigger lost because PEND was saturated
ERR_UNDERRUN  out  1  sticky: at least one pad word was emitted

Behaviour:
- Reset values: RD_EN=0, DOUT=0, DOUT_VLD=0, DOUT_LAST=0, PEND=0, TRIG_OVF=0, ERR_UNDERRUN=0, state=Idle.
- Pending counter:
  - TRIG increments PEND; PEND saturates at 15.
  - TRIG while PEND=15 sets TRIG_OVF.
  - Done state decrements PEND; TRIG and decrement in the same cycle leave PEND unchanged.
  - TRIG is ignored while FIFO_RDY=0.
- FSM states:
  - Idle: if FIFO_RDY and PEND>0 -> Read; ch=0, wcnt=0, tmo=0.
  - Read:
    - If !EMPTY[ch]: RD_EN[ch]=1 combinationally, wcnt++, tmo=0.
    - If EMPTY[ch]: RD_EN=0, tmo++; when tmo reaches TMO-1 -> Pad.
    - When wcnt wraps past BURST-1: ch++ and wcnt=0; after ch=NFIFO-1 -> Done.
  - Pad: emits one pad word (all ones) per cycle for the remaining words of the current channel and sets ERR_UNDERRUN. Then continues with the next channel in Read, or goes to Done after the last channel.
  - Done: one cycle; decrements PEND; -> Idle.
- Output pipeline:
  - RD_EN in cycle n gives DIN in cycle n+1, registered to DOUT with DOUT_VLD=1 in cycle n+2.
  - Pad words use the same 2-stage delay, so output order always equals read order.
  - DOUT_LAST travels as a tag with the final word; it is high for exactly one cycle per event.
  - No DOUT_VLD gaps other than empty stalls.
- Each event always emits exactly NFIFO*BURST words: real words plus pad words.
- Back-to-back events: Done -> Idle -> Read costs 2 cycles with no RD_EN. The pipeline drains into the next event without reordering.
- FIFO_RDY falling, any state:
  - Next cycle state=Idle and RD_EN=0.
  - PEND cleared to 0.
  - TRIG_OVF and ERR_UNDERRUN cleared.
  - Pipeline valid bits flushed, so no DOUT_VLD or DOUT_LAST after the drop cycle.
- Async RST mid-event: all outputs return to reset values immediately.
- Word and channel counters are sized ceil(log2(BURST)) and ceil(log2(NFIFO)); they are never compared beyond BURST-1 or NFIFO-1.

Test Plan:
1. FIFO_RDY=1, all FIFOs preloaded with 16 words (value ch*256+index), TRIG in cycle 0 -> RD_EN[0] in cycle 2, first DOUT_VLD in cycle 4 with DOUT=0x000. Then 96 contiguous words 0x000..0x00F, 0x100..0x50F. DOUT_LAST on 0x50F; PEND back to 0; ERR_UNDERRUN=0.
2. FIFO 3 holds only 10 words -> after word 0x309, stall of TMO-1=7 cycles, then 6 pad words 0xFFF. ERR_UNDERRUN=1; FIFO 4 still read; 96 words total.
3. Three TRIG pulses 1 cycle apart -> PEND reaches 3. Events are emitted back to back with 2-cycle RD_EN gaps; three DOUT_LAST pulses; PEND=0 at end.
4. 16 TRIG pulses with FIFOs empty and FIFO_RDY=1 -> PEND saturates at 15 and TRIG_OVF=1. TRIG coincident with Done leaves PEND unchanged.
5. FIFO_RDY dropped during channel 2 of an event -> RD_EN=0 next cycle. No DOUT_VLD after the drop, no DOUT_LAST, PEND=0, error flags cleared.
6. RST asserted asynchronously mid-Read -> all outputs zero without a clock edge. After release with FIFO_RDY=1 and PEND=0, stays in Idle.

Source files
------------

// File: rtl/fifo_rdout_sched.sv
// fifo_rdout_sched
//   Readout scheduler for the per-ADC sample FIFOs. Each accepted trigger
//   reads BURST words from every channel FIFO in order (0..NFIFO-1) and
//   merges them into one stream. An empty FIFO is waited on for up to TMO-1
//   cycles. After that, the rest of that channel's burst is filled with
//   all-ones pad words, so every event is exactly NFIFO*BURST words long.
//   When FIFO_RDY drops, the scheduler aborts, clears its counters and
//   flags, and flushes the output pipeline.
//
// Ports
//   CLK, RST      clock; asynchronous active-high reset
//   FIFO_RDY      level; readout permitted while high
//   TRIG          one-cycle readout request per event
//   EMPTY[k]      empty flag of channel FIFO k
//   DIN           packed FIFO data, channel k at [k*WORD_W +: WORD_W],
//                 valid the cycle after RD_EN[k]
//   RD_EN         one-hot (or zero) read strobe, combinational from state
//   DOUT/_VLD     merged word stream, two cycles after the read/pad slot
//   DOUT_LAST     final word of an event
//   PEND          pending trigger count, saturating at 15
//   TRIG_OVF      sticky: trigger dropped at PEND=15
//   ERR_UNDERRUN  sticky: a pad word was generated
module fifo_rdout_sched #(
  parameter int NFIFO  = 6,
  parameter int WORD_W = 12,
  parameter int BURST  = 16,
  parameter int TMO    = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    FIFO_RDY,
  input  logic                    TRIG,
  input  logic [NFIFO-1:0]        EMPTY,
  input  logic [NFIFO*WORD_W-1:0] DIN,
  output logic [NFIFO-1:0]        RD_EN,
  output logic [WORD_W-1:0]       DOUT,
  output logic                    DOUT_VLD,
  output logic                    DOUT_LAST,
  output logic [3:0]              PEND,
  output logic                    TRIG_OVF,
  output logic                    ERR_UNDERRUN
);

  localparam int CW     = (NFIFO > 1) ? $clog2(NFIFO) : 1;
  localparam int WW     = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int TW     = $clog2(TMO);
  localparam int STAGES = 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_PAD  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state;
  logic [CW-1:0]     ch;
  logic [WW-1:0]     wcnt;
  logic [TW-1:0]     tmo;

  logic [NFIFO-1:0]  ch_oh;
  logic              emp_cur, ch_last, w_last;
  logic              rd_go, pad_go, issue, issue_last;

  // vld_pipe[0]/last_pipe[0]: data stage (DIN valid), [1]: output register
  logic [STAGES:0]   vld_pipe, last_pipe;
  logic              s1_pad;
  logic [CW-1:0]     s1_ch;
  logic [WORD_W-1:0] din_sel;

  always_comb begin
    ch_oh = '0;
    for (int k = 0; k < NFIFO; k++) ch_oh[k] = (ch == CW'(k));
  end

  assign emp_cur    = |(EMPTY & ch_oh);
  assign ch_last    = (ch == CW'(NFIFO - 1));
  assign w_last     = (wcnt == WW'(BURST - 1));
  // Gating with FIFO_RDY stops reads in the drop cycle itself, so no word is
  // pulled from a FIFO whose data would then be flushed.
  assign rd_go      = FIFO_RDY && (state == S_READ) && !emp_cur;
  assign pad_go     = FIFO_RDY && (state == S_PAD);
  assign issue      = rd_go || pad_go;
  assign issue_last = issue && ch_last && w_last;
  assign RD_EN      = rd_go ? ch_oh : '0;

  // Scheduler FSM
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
      ch    <= '0;
      wcnt  <= '0;
      tmo   <= '0;
    end else if (!FIFO_RDY) begin
      state <= S_IDLE;
      ch    <= '0;
      wcnt  <= '0;
      tmo   <= '0;
    end else begin
      case (state)
        S_IDLE: if (PEND != 4'd0) begin
          state <= S_READ;
          ch    <= '0;
          wcnt  <= '0;
          tmo   <= '0;
        end
        S_READ: if (!emp_cur) begin
          tmo <= '0;
          if (w_last) begin
            wcnt <= '0;
            if (ch_last) state <= S_DONE;
            else         ch    <= ch + CW'(1);
          end else begin
            wcnt <= wcnt + WW'(1);
          end
        end else if (tmo == TW'(TMO - 2)) begin
          // This is stall cycle TMO-1 on the same FIFO, so give up on it.
          state <= S_PAD;
          tmo   <= '0;
        end else begin
          tmo <= tmo + TW'(1);
        end
        S_PAD: if (w_last) begin
          wcnt <= '0;
          if (ch_last) state <= S_DONE;
          else begin
            ch    <= ch + CW'(1);
            state <= S_READ;
          end
        end else begin
          wcnt <= wcnt + WW'(1);
        end
        default: state <= S_IDLE;  // S_DONE
      endcase
    end
  end

  // Pending count and sticky flags
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      PEND         <= '0;
      TRIG_OVF     <= 1'b0;
      ERR_UNDERRUN <= 1'b0;
    end else if (!FIFO_RDY) begin
      PEND         <= '0;
      TRIG_OVF     <= 1'b0;
      ERR_UNDERRUN <= 1'b0;
    end else begin
      // A trigger in the Done cycle replaces the completed event, so the
      // count does not change.
      if (TRIG && state != S_DONE) begin
        if (PEND == 4'hF) TRIG_OVF <= 1'b1;
        else              PEND     <= PEND + 4'd1;
      end else if (!TRIG && state == S_DONE) begin
        PEND <= PEND - 4'd1;
      end
      if (pad_go) ERR_UNDERRUN <= 1'b1;
    end
  end

  always_comb begin
    din_sel = '0;
    for (int k = 0; k < NFIFO; k++)
      if (s1_ch == CW'(k)) din_sel = DIN[k*WORD_W +: WORD_W];
  end

  // Output pipeline: pad slots travel with real reads, so order is preserved.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
      s1_pad    <= 1'b0;
      s1_ch     <= '0;
      DOUT      <= '0;
    end else begin
      vld_pipe  <= FIFO_RDY ? {vld_pipe[STAGES-1:0], issue}      : '0;
      last_pipe <= FIFO_RDY ? {last_pipe[STAGES-1:0], issue_last} : '0;
      s1_pad    <= pad_go;
      s1_ch     <= ch;
      if (vld_pipe[0]) DOUT <= s1_pad ? '1 : din_sel;
    end
  end

  assign DOUT_VLD  = vld_pipe[STAGES];
  assign DOUT_LAST = last_pipe[STAGES];

endmodule

// File: tb/tb_fifo_rdout_sched.sv
// Directed bench for fifo_rdout_sched. FIFO k is modelled as a counter
// source that returns k*256 + (words read since the last load). Its depth
// is set per test. A negedge collector logs output words and read strobes
// with their cycle numbers, and the main sequence checks those logs.
module tb_fifo_rdout_sched;
  localparam int NF = 6;
  localparam int W  = 12;

  logic          CLK = 1'b0;
  logic          RST;
  logic          FIFO_RDY;
  logic          TRIG;
  logic [NF-1:0] EMPTY;
  logic [NF*W-1:0] DIN;
  logic [NF-1:0] RD_EN;
  logic [W-1:0]  DOUT;
  logic          DOUT_VLD, DOUT_LAST;
  logic [3:0]    PEND;
  logic          TRIG_OVF, ERR_UNDERRUN;

  fifo_rdout_sched #(.NFIFO(NF), .WORD_W(W), .BURST(16), .TMO(8)) dut (
    .CLK(CLK), .RST(RST), .FIFO_RDY(FIFO_RDY), .TRIG(TRIG), .EMPTY(EMPTY),
    .DIN(DIN), .RD_EN(RD_EN), .DOUT(DOUT), .DOUT_VLD(DOUT_VLD),
    .DOUT_LAST(DOUT_LAST), .PEND(PEND), .TRIG_OVF(TRIG_OVF),
    .ERR_UNDERRUN(ERR_UNDERRUN));

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // FIFO model
  int rd_total [NF];
  int base     [NF];
  int avail    [NF];

  always_comb begin
    EMPTY = '0;
    for (int k = 0; k < NF; k++) EMPTY[k] = (rd_total[k] - base[k]) >= avail[k];
  end

  always @(posedge CLK)
    for (int k = 0; k < NF; k++)
      if (RD_EN[k]) begin
        DIN[k*W +: W] <= W'(k*256 + rd_total[k] - base[k]);
        rd_total[k]   <= rd_total[k] + 1;
      end

  // Collector
  logic [W-1:0] out_w [4096];
  int           out_c [4096];
  logic         out_l [4096];
  int           rd_c  [4096];
  int n_out = 0, n_last = 0, n_rd = 0, n_oh = 0;

  always @(negedge CLK) begin
    if (DOUT_VLD) begin
      out_w[n_out] <= DOUT;
      out_c[n_out] <= cyc;
      out_l[n_out] <= DOUT_LAST;
      n_out        <= n_out + 1;
    end
    if (DOUT_LAST) n_last <= n_last + 1;
    if (RD_EN != '0) begin
      rd_c[n_rd] <= cyc;
      n_rd       <= n_rd + 1;
      if (!$onehot(RD_EN)) n_oh <= n_oh + 1;
    end
  end

  int npass = 0, ntot = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
    #1;
  endtask

  task automatic load(input int k, input int n);
    base[k]  = rd_total[k];
    avail[k] = n;
  endtask

  task automatic load_all(input int n);
    for (int k = 0; k < NF; k++) load(k, n);
  endtask

  task automatic pulse;
    TRIG = 1'b1; tick(1); TRIG = 1'b0;
  endtask

  initial begin
    int t0, o0, r0, l0, o1, l1, rr, errs, chn, idx, e, j, ex, gap;
    RST = 1'b1; FIFO_RDY = 1'b0; TRIG = 1'b0;
    for (int k = 0; k < NF; k++) begin base[k] = 0; avail[k] = 0; end
    tick(2);
    check("rst_rd_en", RD_EN, 0);
    check("rst_dout", DOUT, 0);
    check("rst_vld_last", {DOUT_VLD, DOUT_LAST}, 0);
    check("rst_pend_flags", {PEND, TRIG_OVF, ERR_UNDERRUN}, 0);
    RST = 1'b0;
    tick(1);

    // 1: full FIFOs, one trigger
    load_all(16); FIFO_RDY = 1'b1; tick(2);
    t0 = cyc; o0 = n_out; r0 = n_rd; l0 = n_last;
    pulse;
    check("t1_pend1", PEND, 1);
    tick(1);
    check("t1_rd_en_c2", RD_EN, 6'b000001);
    tick(110);
    check("t1_nwords", n_out - o0, 96);
    check("t1_first_cyc", out_c[o0] - t0, 4);
    check("t1_first_word", out_w[o0], 0);
    check("t1_last_word", out_w[o0+95], 'h50F);
    errs = 0;
    for (int i = 0; i < 96; i++) begin
      if (out_w[o0+i] !== W'((i/16)*256 + i%16)) errs++;
      if (i > 0 && out_c[o0+i] != out_c[o0+i-1] + 1) errs++;
      if (out_l[o0+i] !== (i == 95)) errs++;
    end
    check("t1_stream_errs", errs, 0);
    check("t1_nlast", n_last - l0, 1);
    check("t1_pend_err", {PEND, ERR_UNDERRUN}, 0);

    // 2: FIFO 3 short by 6 words
    load_all(16); load(3, 10);
    o0 = n_out; l0 = n_last;
    pulse; tick(130);
    check("t2_nwords", n_out - o0, 96);
    errs = 0;
    for (int i = 0; i < 96; i++) begin
      chn = i/16; idx = i%16;
      ex  = (chn == 3 && idx >= 10) ? 'hFFF : chn*256 + idx;
      gap = (i == 58) ? 8 : 1;
      if (out_w[o0+i] !== W'(ex)) errs++;
      if (i > 0 && out_c[o0+i] - out_c[o0+i-1] != gap) errs++;
    end
    check("t2_stream_errs", errs, 0);
    check("t2_word_0x309", out_w[o0+57], 'h309);
    check("t2_stall_gap", out_c[o0+58] - out_c[o0+57], 8);
    check("t2_err_underrun", ERR_UNDERRUN, 1);
    check("t2_nlast_pend", {n_last - l0, 28'(PEND)}, {32'd1} << 28);

    // 3: three triggers, events back to back
    load_all(48);
    o0 = n_out; r0 = n_rd; l0 = n_last;
    pulse; tick(1); pulse; tick(1); pulse;
    check("t3_pend3", PEND, 3);
    tick(330);
    check("t3_nwords", n_out - o0, 288);
    check("t3_nlast", n_last - l0, 3);
    errs = 0;
    for (int i = 0; i < 288; i++) begin
      e = i/96; j = i%96;
      ex  = (j/16)*256 + e*16 + j%16;
      gap = (j == 0) ? 3 : 1;
      if (out_w[o0+i] !== W'(ex)) errs++;
      if (i > 0 && out_c[o0+i] - out_c[o0+i-1] != gap) errs++;
      if (out_l[o0+i] !== (j == 95)) errs++;
    end
    check("t3_stream_errs", errs, 0);
    check("t3_rd_gap", rd_c[r0+96] - rd_c[r0+95], 3);
    check("t3_rd_gap2", rd_c[r0+192] - rd_c[r0+191], 3);
    check("t3_pend0", PEND, 0);

    // 4: saturation with empty FIFOs, then abort via FIFO_RDY
    TRIG = 1'b1; tick(16); TRIG = 1'b0;
    check("t4_pend15", PEND, 15);
    check("t4_ovf", TRIG_OVF, 1);
    FIFO_RDY = 1'b0; tick(1);
    check("t4_drop_clear", {PEND, TRIG_OVF, ERR_UNDERRUN, DOUT_VLD}, 0);
    check("t4_drop_rd_en", RD_EN, 0);
    FIFO_RDY = 1'b1; tick(2);

    // TRIG coincident with Done keeps PEND unchanged
    load_all(32);
    o0 = n_out; r0 = n_rd; l0 = n_last;
    pulse;
    for (int i = 0; i < 200 && (n_rd - r0) < 96; i++) tick(1);
    check("td_reads", n_rd - r0, 96);
    tick(1);
    TRIG = 1'b1;
    check("td_pend_in_done", PEND, 1);
    tick(1); TRIG = 1'b0;
    check("td_pend_kept", PEND, 1);
    tick(120);
    check("td_pend0", PEND, 0);
    check("td_nlast", n_last - l0, 2);
    check("td_nwords", n_out - o0, 192);
    check("onehot_viol", n_oh, 0);

    // 5: FIFO_RDY drop during channel 2
    load_all(16); load(0, 10);
    o0 = n_out; r0 = n_rd; l0 = n_last;
    pulse; tick(1); pulse; tick(1); pulse;
    for (int i = 0; i < 200 && (n_rd - r0) < 32; i++) tick(1);
    check("t5_reached_ch2", n_rd - r0, 32);
    check("t5_pend3_err", {PEND, ERR_UNDERRUN}, {4'd3, 1'b1});
    FIFO_RDY = 1'b0; tick(1);
    check("t5_rd_en0", RD_EN, 0);
    check("t5_clear", {PEND, TRIG_OVF, ERR_UNDERRUN}, 0);
    check("t5_vld0", DOUT_VLD, 0);
    o1 = n_out; l1 = n_last;
    pulse; tick(4);
    check("t5_no_words", n_out - o1, 0);
    check("t5_no_last", n_last - l0, 0);
    check("t5_trig_ignored", PEND, 0);
    FIFO_RDY = 1'b1; rr = n_rd; tick(6);
    check("t5_idle_rd", n_rd - rr, 0);
    check("t5_idle_pend", PEND, 0);

    // 6: async reset mid-read
    load_all(16); r0 = n_rd;
    pulse;
    for (int i = 0; i < 200 && (n_rd - r0) < 20; i++) tick(1);
    check("t6_active", DOUT_VLD, 1);
    RST = 1'b1; #1;
    check("t6_rst_rd_en", RD_EN, 0);
    check("t6_rst_dout", DOUT, 0);
    check("t6_rst_vld_last", {DOUT_VLD, DOUT_LAST}, 0);
    check("t6_rst_pend_flags", {PEND, TRIG_OVF, ERR_UNDERRUN}, 0);
    tick(2); RST = 1'b0;
    rr = n_rd; tick(6);
    check("t6_idle_rd", n_rd - rr, 0);
    check("t6_idle_pend", {PEND, RD_EN}, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
